program_counter: RTL and testbench

//   Architectural program-counter register for the single-cycle RV32 datapath.

---
 rtl/rv_pkg.sv | 11 +
 rtl/program_counter.sv | 37 +++
 tb/tb_program_counter.sv | 106 ++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 datapath constants and types: architectural width, address type
// and the program-counter reset vector.
package rv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_PC = 32'h0000_0000;

endpackage : rv_pkg

// File: rtl/program_counter.sv
// Architectural program-counter register: loads the next-PC value every clock.
// Optional feature macro PC_ALIGN_EN forces PC[1:0] to zero on every load.
module program_counter
    import rv_pkg::*;
#(
    parameter int                WIDTH        = XLEN,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PCNext,
    output logic [WIDTH-1:0] PC
);

`ifdef PC_ALIGN_EN
    // Word-aligned fetch: a misaligned target never reaches instruction memory.
    localparam logic [WIDTH-1:0] RESET_VALUE = {RESET_VECTOR[WIDTH-1:2], 2'b00};

    logic [WIDTH-1:0] load_s;
    assign load_s = {PCNext[WIDTH-1:2], 2'b00};
`else
    localparam logic [WIDTH-1:0] RESET_VALUE = RESET_VECTOR;

    logic [WIDTH-1:0] load_s;
    assign load_s = PCNext;
`endif

    // PC register: reset wins, otherwise reload unconditionally every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= RESET_VALUE;
        end else begin
            PC <= load_s;
        end
    end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed steps followed by a
// randomized phase compared against a behavioural model of the PC register.
`timescale 1ns/1ps
module tb_program_counter;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pcnext;
    logic [31:0] pc;

    int vectors;
    int miscompares;
    logic [31:0] model_pc;

    program_counter dut (
        .clk    (clk),
        .reset  (reset),
        .PCNext (pcnext),
        .PC     (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the register should hold after loading a given next-PC value.
    function automatic logic [31:0] loaded(input logic [31:0] v);
`ifdef PC_ALIGN_EN
        return v & 32'hFFFF_FFFC;
`else
        return v;
`endif
    endfunction

    function automatic logic [31:0] reset_value();
        return loaded(RV);
    endfunction

    task automatic check(input string tag, input logic [31:0] expected);
        vectors++;
        assert (pc === expected)
        else begin
            miscompares++;
            $error("FAIL %s: PC=%h expected %h", tag, pc, expected);
        end
    endtask

    // Drive inputs, take one rising edge, update the model, compare #1 later.
    task automatic cycle(input logic r, input logic [31:0] nx, input string tag);
        reset  = r;
        pcnext = nx;
        @(posedge clk);
        model_pc = r ? reset_value() : loaded(nx);
        #1;
        check(tag, model_pc);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        pcnext      = 32'hx;
        @(negedge clk);

        // 1: reset held with unknown next-PC
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hx, "reset_hold");

        // 2: release; value must not appear before the edge
        reset  = 1'b0;
        pcnext = 32'h0000_0004;
        #2;
        check("no_comb_path", reset_value());
        cycle(1'b0, 32'h0000_0004, "release_first_load");

        // 3: sequential fetch
        for (int a = 8; a <= 32'h18; a += 4) cycle(1'b0, 32'(a), "seq_step");

        // 4: jump, then mid-run reset, then release
        cycle(1'b0, 32'h0000_0100, "jump");
        cycle(1'b1, 32'h0000_0100, "mid_reset");
        cycle(1'b0, 32'h0000_0008, "post_reset_load");

        // repeated value still loads, and stays stable between edges
        cycle(1'b0, 32'h0000_0008, "repeat_load");
        #3;
        check("stable_between_edges", loaded(32'h0000_0008));

        // 5: top of address space and back to zero
        cycle(1'b0, 32'hFFFF_FFFC, "top_address");
        cycle(1'b0, 32'h0000_0000, "wrap_zero");

        // 6: misaligned target
        cycle(1'b0, 32'h0000_0013, "misaligned");
        cycle(1'b0, 32'hFFFF_FFFF, "all_ones");

        // randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, $urandom, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_program_counter
